// File: rtl/uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// uart_fifo_tx
//   UART transmitter that pulls bytes from a first-word-fall-through FIFO.
//   It sends one start bit (0), DBITS data bits LSB first and one stop bit (1).
//   Each bit is held for CLKS_PER_BIT clocks. When the FIFO has data at the
//   last cycle of a stop bit, the next word is popped and its start bit begins
//   on that same edge, so back-to-back frames have no idle gap.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   DBITS        : data bits per frame, equal to the FIFO data width
//
// Ports
//   CLK_I     in   clock; every state change happens on its rising edge
//   RST_I     in   asynchronous active-high reset; aborts any frame at once
//   EMPTY_I   in   FIFO empty flag
//   R_DATA_I  in   FIFO head word, valid while EMPTY_I=0
//   RE_O      out  FIFO pop strobe (combinational)
//   TX_O      out  serial line, idle high, registered
//   BUSY_O    out  high whenever the FSM is not idle
//   DONE_O    out  one-cycle registered pulse after each stop bit completes
// ----------------------------------------------------------------------------
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DBITS        = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             EMPTY_I,
  input  logic [DBITS-1:0] R_DATA_I,
  output logic             RE_O,
  output logic             TX_O,
  output logic             BUSY_O,
  output logic             DONE_O
);

  // A counter needs at least one bit, even when the range it covers is 1.
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  // The pop is gated by reset directly so that no word is consumed while
  // reset is asserted, even though the state registers are already cleared.
  assign RE_O = !RST_I && !EMPTY_I &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

  // NOTE: every next-state value gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (RE_O) begin
          state_d = S_START;
          shift_d = R_DATA_I;
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift right so the next data bit is always at position 0.
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          done_d = 1'b1;
          baud_d = '0;
          if (RE_O) begin
            // Back-to-back: the next start bit begins on this same edge.
            state_d = S_START;
            shift_d = R_DATA_I;
            idx_d   = '0;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign TX_O   = tx_q;
  assign BUSY_O = (state_q != S_IDLE);
  assign DONE_O = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_fifo_tx
//   Directed bench for uart_fifo_tx. Instance A uses CLKS_PER_BIT=4 and
//   instance B uses CLKS_PER_BIT=2; both share the clock and reset. Inputs
//   change on the falling edge, and outputs are sampled 1 ns later, which is
//   well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_uart_fifo_tx;

  logic       clk;
  logic       rst;
  logic       empty_a, empty_b;
  logic [7:0] data_a, data_b;
  logic       re_a, tx_a, busy_a, done_a;
  logic       re_b, tx_b, busy_b, done_b;

  int n_pass  = 0;
  int n_total = 0;

  uart_fifo_tx #(.CLKS_PER_BIT(4), .DBITS(8)) dut_a (
    .CLK_I(clk), .RST_I(rst), .EMPTY_I(empty_a), .R_DATA_I(data_a),
    .RE_O(re_a), .TX_O(tx_a), .BUSY_O(busy_a), .DONE_O(done_a)
  );

  uart_fifo_tx #(.CLKS_PER_BIT(2), .DBITS(8)) dut_b (
    .CLK_I(clk), .RST_I(rst), .EMPTY_I(empty_b), .R_DATA_I(data_b),
    .RE_O(re_b), .TX_O(tx_b), .BUSY_O(busy_b), .DONE_O(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, apply the inputs, and let them settle.
  task automatic drive_a(input logic e, input logic [7:0] d);
    @(negedge clk);
    empty_a = e;
    data_a  = d;
    #1;
  endtask

  task automatic drive_b(input logic e, input logic [7:0] d);
    @(negedge clk);
    empty_b = e;
    data_b  = d;
    #1;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    empty_a = 1'b0;  // the FIFO has data, but reset must block the pop
    data_a  = 8'h55;
    empty_b = 1'b0;
    data_b  = 8'h55;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++; if (tx_a !== 1'b1)   $display("FAIL reset_tx got=%b exp=1", tx_a);     else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else n_pass++;
    n_total++; if (done_a !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_a); else n_pass++;
    n_total++; if (re_a !== 1'b0)   $display("FAIL reset_re_a got=%b exp=0", re_a);   else n_pass++;
    n_total++; if (re_b !== 1'b0)   $display("FAIL reset_re_b got=%b exp=0", re_b);   else n_pass++;
    n_total++; if (tx_b !== 1'b1)   $display("FAIL reset_tx_b got=%b exp=1", tx_b);   else n_pass++;
    @(negedge clk);
    rst     = 1'b0;
    empty_a = 1'b1;
    empty_b = 1'b1;
    #1;
    n_total++; if (re_a !== 1'b0) $display("FAIL release_re got=%b exp=0", re_a); else n_pass++;
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      drive_a(1'b1, 8'hC3);
      n_total++;
      if (tx_a !== 1'b1 || re_a !== 1'b0 || busy_a !== 1'b0) begin
        if (bad < 4) $display("FAIL idle cyc=%0d tx=%b re=%b busy=%b exp tx=1 re=0 busy=0", k, tx_a, re_a, busy_a);
        bad++;
      end else n_pass++;
    end
  endtask

  // Send one frame on instance A. With noise set, EMPTY_I toggles and
  // R_DATA_I is random in every frame cycle except the last stop cycle.
  task automatic send_frame_a(input logic [7:0] byte_v, input bit noise, input string tag);
    logic [9:0] pat;
    logic       exp;
    pat = {1'b1, byte_v, 1'b0};  // bit 0 is sent first
    drive_a(1'b0, byte_v);
    n_total++; if (re_a !== 1'b1) $display("FAIL %s_pop got=%b exp=1", tag, re_a); else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      if (noise && k < 40) drive_a((k % 2) == 1, 8'($urandom));
      else                 drive_a(1'b1, 8'h00);
      exp = pat[(k - 1) / 4];
      n_total++; if (tx_a !== exp)    $display("FAIL %s_tx cyc=%0d got=%b exp=%b", tag, k, tx_a, exp); else n_pass++;
      n_total++; if (re_a !== 1'b0)   $display("FAIL %s_re cyc=%0d got=%b exp=0", tag, k, re_a);       else n_pass++;
      n_total++; if (busy_a !== 1'b1) $display("FAIL %s_busy cyc=%0d got=%b exp=1", tag, k, busy_a);   else n_pass++;
      n_total++; if (done_a !== 1'b0) $display("FAIL %s_done cyc=%0d got=%b exp=0", tag, k, done_a);   else n_pass++;
    end
    drive_a(1'b1, 8'h00);
    n_total++; if (done_a !== 1'b1) $display("FAIL %s_done_end got=%b exp=1", tag, done_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL %s_busy_end got=%b exp=0", tag, busy_a); else n_pass++;
    n_total++; if (tx_a !== 1'b1)   $display("FAIL %s_tx_end got=%b exp=1", tag, tx_a);     else n_pass++;
    drive_a(1'b1, 8'h00);
    n_total++; if (done_a !== 1'b0) $display("FAIL %s_done_pulse got=%b exp=0", tag, done_a); else n_pass++;
  endtask

  task automatic test_single_byte;
    send_frame_a(8'hA5, 1'b0, "a5");
  endtask

  task automatic test_input_noise;
    send_frame_a(8'h3C, 1'b1, "noise3c");
  endtask

  // 0x00 then 0xFF: the second pop happens in the last stop cycle of the
  // first frame, 40 cycles after the first, with no idle cycle in between.
  task automatic test_back_to_back;
    logic [9:0] p0, p1;
    logic       exp_tx;
    p0 = {1'b1, 8'h00, 1'b0};
    p1 = {1'b1, 8'hFF, 1'b0};
    drive_a(1'b0, 8'h00);
    n_total++; if (re_a !== 1'b1) $display("FAIL b2b_pop0 got=%b exp=1", re_a); else n_pass++;
    for (int k = 1; k <= 80; k++) begin
      drive_a(k > 40, 8'hFF);
      exp_tx = (k <= 40) ? p0[(k - 1) / 4] : p1[(k - 41) / 4];
      n_total++; if (tx_a !== exp_tx)         $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", k, tx_a, exp_tx);     else n_pass++;
      n_total++; if (re_a !== (k == 40))      $display("FAIL b2b_re cyc=%0d got=%b exp=%b", k, re_a, k == 40);    else n_pass++;
      n_total++; if (done_a !== (k == 41))    $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, done_a, k == 41); else n_pass++;
      n_total++; if (busy_a !== 1'b1)         $display("FAIL b2b_busy cyc=%0d got=%b exp=1", k, busy_a);         else n_pass++;
    end
    drive_a(1'b1, 8'h00);
    n_total++; if (done_a !== 1'b1) $display("FAIL b2b_done_end got=%b exp=1", done_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", busy_a); else n_pass++;
    n_total++; if (tx_a !== 1'b1)   $display("FAIL b2b_tx_end got=%b exp=1", tx_a);     else n_pass++;
  endtask

  // CLKS_PER_BIT=2, byte 0x01: 0,0 then 1,1 then 14 zeros then 1,1.
  task automatic test_fast_baud;
    logic [19:0] exp_seq;
    exp_seq = 20'b11_00000000000000_11_00;  // cycle 1 is bit 0
    drive_b(1'b0, 8'h01);
    n_total++; if (re_b !== 1'b1) $display("FAIL b_pop got=%b exp=1", re_b); else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      drive_b(1'b1, 8'h00);
      n_total++; if (tx_b !== exp_seq[k - 1]) $display("FAIL b_tx cyc=%0d got=%b exp=%b", k, tx_b, exp_seq[k - 1]); else n_pass++;
      n_total++; if (busy_b !== 1'b1)         $display("FAIL b_busy cyc=%0d got=%b exp=1", k, busy_b);              else n_pass++;
    end
    drive_b(1'b1, 8'h00);
    n_total++; if (done_b !== 1'b1) $display("FAIL b_done got=%b exp=1", done_b); else n_pass++;
    n_total++; if (busy_b !== 1'b0) $display("FAIL b_busy_end got=%b exp=0", busy_b); else n_pass++;
  endtask

  // Reset in the middle of data bit 3 of 0x00, between two clock edges.
  task automatic test_reset_mid_frame;
    drive_a(1'b0, 8'h00);
    n_total++; if (re_a !== 1'b1) $display("FAIL mid_pop got=%b exp=1", re_a); else n_pass++;
    for (int k = 1; k <= 18; k++) drive_a(1'b1, 8'h00);
    n_total++; if (tx_a !== 1'b0)   $display("FAIL mid_pre_tx got=%b exp=0", tx_a);     else n_pass++;
    n_total++; if (busy_a !== 1'b1) $display("FAIL mid_pre_busy got=%b exp=1", busy_a); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (tx_a !== 1'b1)   $display("FAIL mid_rst_tx got=%b exp=1", tx_a);     else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy_a); else n_pass++;
    drive_a(1'b1, 8'h00);
    drive_a(1'b1, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      drive_a(1'b1, 8'h00);
      n_total++;
      if (re_a !== 1'b0 || done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0)
        $display("FAIL mid_after cyc=%0d re=%b done=%b tx=%b busy=%b exp re=0 done=0 tx=1 busy=0",
                 k, re_a, done_a, tx_a, busy_a);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_input_noise();
    test_fast_baud();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
